prog_ram_loader: RTL
====================

# prog_ram_loader

Byte-serial program loader and instruction memory for the `micro` core. It replaces a hard-wired instruction ROM with a writable program RAM. A host streams a length byte followed by big-endian 16-bit instruction words over a valid/ready byte handshake, and the block writes them into RAM. While it loads, it holds the core off with `cpu_hold`. Its read side presents `IR = mem[PC]` to the core with the same combinational timing as a ROM.

## Interface
- `DEPTH`, 32: number of 16-bit program words. Legal range is 1..255.
- `HLT_WORD`, 16'hF000: fill value, and the value read from any unloaded or out-of-range location.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high. Clears all state and fills the RAM with `HLT_WORD`.
- `load_start`  in  1: level-sampled each edge. When sampled 1, a new load (re)starts.
- `byte_in`  in  8: serial data byte.
- `byte_valid`  in  1: `byte_in` is valid this cycle.
- `byte_ready`  out  1: block accepts a byte this cycle. A transfer happens on any edge where `byte_valid & byte_ready`.
- `PC`  in  8: read address from the core.
- `IR`  out  16: instruction word, combinational.
- `cpu_hold`  out  1: registered. While high, the core must be held or clock-gated.
- `load_done`  out  1: one-cycle pulse when a load completes successfully.
- `err`  out  1: sticky header error flag.
- `word_count`  out  8: number of words written in the current or last load.

## Operation
- **State machine:** IDLE, LEN, HI, LO, DONE. State is IDLE after reset.
- **`byte_ready`:** equals 1 exactly in LEN, HI and LO. It is combinational from state.
- **`load_start`:** sampled 1 in any state moves the block to LEN at the next edge. The same edge clears the word pointer, `word_count` and `err`, and sets `cpu_hold` = 1.
  - `load_start` has priority over a simultaneous byte transfer. That byte is consumed and discarded.
  - Words already written before a restart stay in RAM.
- **LEN:** on transfer, latch N = `byte_in`.
  - If N = 0 or N > `DEPTH`: set `err` = 1 and go to IDLE. `cpu_hold` stays 1 until the next successful load.
  - Otherwise go to HI.
- **HI:** on transfer, latch the high byte and go to LO.
- **LO:** on transfer, write `mem[ptr] = {hi, byte_in}`, increment `ptr` and `word_count`.
  - If `ptr`+1 == N, go to DONE.
  - Otherwise go to HI.
- **DONE:** `load_done` = 1 for this cycle. At the next edge, go to IDLE and clear `cpu_hold`.
- **Read port:**
  - `IR = mem[PC]` when `PC < DEPTH`; otherwise `IR = HLT_WORD`.
  - `IR` is forced to `HLT_WORD` whenever `cpu_hold` = 1.
- **Width rules:**
  - `ptr` is 8 bits and never wraps, because N ≤ `DEPTH` ≤ 255.
  - `word_count` saturates implicitly at N.
- **Bytes outside a load:** bytes presented in IDLE or DONE are not accepted (`byte_ready` = 0).

## Timing
- **Reset values:**
  - `cpu_hold` = 0, `load_done` = 0, `err` = 0, `word_count` = 0, `byte_ready` = 0.
  - State = IDLE.
  - All RAM words = `HLT_WORD`, so `IR` = 16'hF000 for any `PC`.
- **Reset mid-load:** asynchronous. It returns the block to the reset values immediately, including re-filling the RAM.
- **Write latency:** a word written at edge k is visible on `IR` once `cpu_hold` falls. That is at edge k+1 when it is the last word, which is the DONE→IDLE edge.
- **Load duration:** a load of N words with `byte_valid` held high takes 1 + 2N transfer edges after the `load_start` edge, plus 1 DONE cycle. Gaps in `byte_valid` stall the state machine without penalty.
- **`load_done`:** high for exactly one cycle, the cycle in which state == DONE. `cpu_hold` is still 1 during that cycle.
- **`err`:** remains 1 until the next `load_start` or reset.

## Test plan
- **Basic load:** reset, then `load_start` pulse; bytes 03,20,00,20,11,F0,00 with `byte_valid` held high. Required response:
  - `load_done` pulses once, 7 transfer edges after `load_start`.
  - `word_count` = 3, then `cpu_hold` falls.
  - `IR` = 2000, 2011 and F000 for `PC` = 0, 1 and 2.
  - `IR` = F000 for `PC` = 3 and for `PC` = 200.
- **Backpressure:** same stream with `byte_valid` toggling 1,0,0,1,... Required response: identical RAM contents; transfers counted only when `byte_ready` & `byte_valid`.
- **Header errors:**
  - Length byte 00 → `err` = 1, state returns to IDLE, `cpu_hold` = 1, no `load_done`, RAM unchanged.
  - Length byte 21 (33 > `DEPTH`) → same response.
- **Restart mid-load:** N = 4 and two words sent; then `load_start` asserted together with a byte transfer. Required response:
  - The byte is discarded and `word_count` = 0.
  - A new N = 1 load of `4401` gives `mem[0]` = 4401 and `mem[1]` = the first load's second word.
- **Reset mid-load:** assert `reset` during an HI cycle. Required response:
  - All outputs return to reset values asynchronously.
  - `IR` = F000 at every `PC`.
  - `byte_ready` = 0 until the next `load_start`.
- **`IR` gating:** during a load, drive `PC` = 0 after word 0 has been written. Required response: `IR` stays F000 until `cpu_hold` falls.

Source files
------------

// File: rtl/prog_ram_loader.sv
// prog_ram_loader: byte-serial program loader feeding a writable instruction RAM.
// Ports: clk/reset (async, active-high); load_start restarts a load;
// byte_in/byte_valid/byte_ready form the host byte handshake;
// PC/IR form the core's combinational read port;
// cpu_hold, load_done, err and word_count report load status.
module prog_ram_loader #(
    parameter int          DEPTH    = 32,
    parameter logic [15:0] HLT_WORD = 16'hF000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic [7:0]  PC,
    output logic [15:0] IR,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        err,
    output logic [7:0]  word_count
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_HI   = 3'd2;
    localparam logic [2:0] S_LO   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [7:0] DEPTH8 = 8'(DEPTH);

    logic [2:0]  state_q, state_d;
    logic [7:0]  n_q, n_d, hi_q, hi_d, ptr_q, ptr_d, cnt_q, cnt_d;
    logic        err_q, err_d, hold_q, hold_d, we;
    logic [15:0] mem_q [DEPTH];
    logic [15:0] rd;
    logic        xfer;

    assign byte_ready = (state_q == S_LEN) || (state_q == S_HI) || (state_q == S_LO);
    assign xfer       = byte_valid && byte_ready;
    assign load_done  = state_q == S_DONE;
    assign cpu_hold   = hold_q;
    assign err        = err_q;
    assign word_count = cnt_q;
    assign IR         = hold_q ? HLT_WORD : rd;

    // Decoding PC against each entry keeps out-of-range addresses on HLT_WORD.
    always_comb begin
        rd = HLT_WORD;
        for (int i = 0; i < DEPTH; i++)
            if (PC == 8'(i)) rd = mem_q[i];
    end

    // A restart wins over any byte transferred on the same edge; that byte is dropped.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        hi_d    = hi_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        hold_d  = hold_q;
        we      = 1'b0;
        if (load_start) begin
            state_d = S_LEN;
            ptr_d   = 8'd0;
            cnt_d   = 8'd0;
            err_d   = 1'b0;
            hold_d  = 1'b1;
        end else begin
            case (state_q)
                S_LEN: if (xfer) begin
                    n_d = byte_in;
                    if (byte_in == 8'd0 || byte_in > DEPTH8) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else state_d = S_HI;
                end
                S_HI: if (xfer) begin
                    hi_d    = byte_in;
                    state_d = S_LO;
                end
                S_LO: if (xfer) begin
                    we      = 1'b1;
                    ptr_d   = ptr_q + 8'd1;
                    cnt_d   = cnt_q + 8'd1;
                    state_d = (ptr_q + 8'd1 == n_q) ? S_DONE : S_HI;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    hold_d  = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            n_q     <= 8'd0;
            hi_q    <= 8'd0;
            ptr_q   <= 8'd0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            hi_q    <= hi_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= HLT_WORD;
        end else if (we) begin
            for (int i = 0; i < DEPTH; i++)
                if (ptr_q == 8'(i)) mem_q[i] <= {hi_q, byte_in};
        end
    end
endmodule
